// File: rtl/eee_imgproc_multi_bbox.sv
// rtl/eee_imgproc_multi_bbox.sv - multi-channel colour match, per-frame bounding boxes, video modify
//
// Purpose: matches every RGB video pixel against NUM_CH inclusive colour windows,
// accumulates one bounding box per channel per frame and can highlight matched
// pixels (mode 1) or draw the previous frame's boxes (mode 2, overlay build only).
// Optional feature macro: EEE_BBOX_OVERLAY_EN enables the mode-2 box overlay;
// without it mode 2 behaves as mode 0.
//
// Ports:
//   clk, reset_n                          clock, asynchronous active-low reset
//   sink_data/valid/ready/sop/eop         Avalon-ST video in, R[23:16] G[15:8] B[7:0]
//   source_data/valid/ready/sop/eop       Avalon-ST video out, one register stage
//   mode                                  0 pass, 1 highlight, 2 overlay, 3 pass
//   thr_lo, thr_hi                        per-channel RGB bounds, ch c at [24c+23:24c]
//   bbox                                  per channel {xmin,xmax,ymin,ymax}, ch 0 in LSBs
//   bbox_valid                            channel matched at least one pixel last frame
//   frame_done                            one-cycle pulse when bbox/bbox_valid update
module eee_imgproc_multi_bbox #(
    parameter int          IMAGE_W     = 640,
    parameter int          IMAGE_H     = 480,
    parameter int          NUM_CH      = 4,
    parameter int          COORD_W     = 11,
    parameter logic [23:0] OVERLAY_RGB = 24'hFF0000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [23:0]                   sink_data,
    input  logic                          sink_valid,
    output logic                          sink_ready,
    input  logic                          sink_sop,
    input  logic                          sink_eop,
    output logic [23:0]                   source_data,
    output logic                          source_valid,
    input  logic                          source_ready,
    output logic                          source_sop,
    output logic                          source_eop,
    input  logic [1:0]                    mode,
    input  logic [NUM_CH*24-1:0]          thr_lo,
    input  logic [NUM_CH*24-1:0]          thr_hi,
    output logic [NUM_CH*4*COORD_W-1:0]   bbox,
    output logic [NUM_CH-1:0]             bbox_valid,
    output logic                          frame_done
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMAGE_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMAGE_H - 1);

    typedef enum logic [1:0] {IDLE, VIDEO, OTHER} state_t;

    state_t              state;
    logic [COORD_W-1:0]  x, y;
    logic                y_over;        // set once the frame has run past its last line
    logic [1:0]          frame_mode;
    logic [NUM_CH-1:0]   found, nxt_found, hit;
    logic [COORD_W-1:0]  acc_xmin [NUM_CH];
    logic [COORD_W-1:0]  acc_xmax [NUM_CH];
    logic [COORD_W-1:0]  acc_ymin [NUM_CH];
    logic [COORD_W-1:0]  acc_ymax [NUM_CH];
    logic [COORD_W-1:0]  nxt_xmin [NUM_CH];
    logic [COORD_W-1:0]  nxt_xmax [NUM_CH];
    logic [COORD_W-1:0]  nxt_ymin [NUM_CH];
    logic [COORD_W-1:0]  nxt_ymax [NUM_CH];
    logic                in_xfer, pix_beat, on_edge;
    logic [23:0]         pix_out;

    assign sink_ready = source_ready | ~source_valid;
    assign in_xfer    = sink_valid & sink_ready;
    assign pix_beat   = in_xfer & ~sink_sop & (state == VIDEO);

    // Window match per channel; pixels beyond the active area never match.
    always_comb begin
        hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            hit[c] = ~y_over;
            for (int k = 0; k < 3; k++) begin
                if ((sink_data[8*k +: 8] < thr_lo[24*c + 8*k +: 8]) ||
                    (sink_data[8*k +: 8] > thr_hi[24*c + 8*k +: 8]))
                    hit[c] = 1'b0;
            end
        end
    end

    // Accumulators including the current beat, so the eop pixel counts too.
    always_comb begin
        nxt_found = found;
        for (int c = 0; c < NUM_CH; c++) begin
            nxt_xmin[c] = acc_xmin[c];
            nxt_xmax[c] = acc_xmax[c];
            nxt_ymin[c] = acc_ymin[c];
            nxt_ymax[c] = acc_ymax[c];
            if (pix_beat && hit[c]) begin
                if (!found[c]) begin
                    nxt_xmin[c] = x;
                    nxt_xmax[c] = x;
                    nxt_ymin[c] = y;
                    nxt_ymax[c] = y;
                end else begin
                    if (x < acc_xmin[c]) nxt_xmin[c] = x;
                    if (x > acc_xmax[c]) nxt_xmax[c] = x;
                    if (y < acc_ymin[c]) nxt_ymin[c] = y;
                    if (y > acc_ymax[c]) nxt_ymax[c] = y;
                end
                nxt_found[c] = 1'b1;
            end
        end
    end

`ifdef EEE_BBOX_OVERLAY_EN
    // Edge test against the boxes published by the previous frame.
    always_comb begin
        on_edge = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bbox_valid[c] && !y_over) begin
                if (((x == bbox[(4*c+3)*COORD_W +: COORD_W]) || (x == bbox[(4*c+2)*COORD_W +: COORD_W])) &&
                    (y >= bbox[(4*c+1)*COORD_W +: COORD_W]) && (y <= bbox[(4*c)*COORD_W +: COORD_W]))
                    on_edge = 1'b1;
                if (((y == bbox[(4*c+1)*COORD_W +: COORD_W]) || (y == bbox[(4*c)*COORD_W +: COORD_W])) &&
                    (x >= bbox[(4*c+3)*COORD_W +: COORD_W]) && (x <= bbox[(4*c+2)*COORD_W +: COORD_W]))
                    on_edge = 1'b1;
            end
        end
    end
`else
    assign on_edge = 1'b0;
`endif

    always_comb begin
        pix_out = sink_data;
        if (frame_mode == 2'd1 && |hit)
            pix_out = 24'hFFFFFF;
        else if (frame_mode == 2'd2 && on_edge)
            pix_out = OVERLAY_RGB;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            y_over       <= 1'b0;
            frame_mode   <= 2'd0;
            found        <= '0;
            source_data  <= '0;
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            bbox         <= '0;
            bbox_valid   <= '0;
            frame_done   <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_xmin[c] <= '0;
                acc_xmax[c] <= '0;
                acc_ymin[c] <= '0;
                acc_ymax[c] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            if (source_ready)
                source_valid <= 1'b0;
            if (in_xfer) begin
                if (sink_sop) begin
                    // Header: forwarded as-is; any partial frame is abandoned.
                    source_valid <= 1'b1;
                    source_data  <= sink_data;
                    source_sop   <= 1'b1;
                    source_eop   <= sink_eop;
                    x      <= '0;
                    y      <= '0;
                    y_over <= 1'b0;
                    found  <= '0;
                    for (int c = 0; c < NUM_CH; c++) begin
                        acc_xmin[c] <= '0;
                        acc_xmax[c] <= '0;
                        acc_ymin[c] <= '0;
                        acc_ymax[c] <= '0;
                    end
                    if (sink_data[3:0] == 4'd0)
                        frame_mode <= mode;
                    if (sink_eop)
                        state <= IDLE;
                    else if (sink_data[3:0] == 4'd0)
                        state <= VIDEO;
                    else
                        state <= OTHER;
                end else if (state != IDLE) begin
                    source_valid <= 1'b1;
                    source_data  <= (state == VIDEO) ? pix_out : sink_data;
                    source_sop   <= 1'b0;
                    source_eop   <= sink_eop;
                    if (state == VIDEO) begin
                        if (x == X_LAST) begin
                            x <= '0;
                            if (y == Y_LAST) y_over <= 1'b1;
                            else             y <= y + 1'b1;
                        end else begin
                            x <= x + 1'b1;
                        end
                        if (sink_eop) begin
                            for (int c = 0; c < NUM_CH; c++) begin
                                bbox[(4*c+3)*COORD_W +: COORD_W] <= nxt_xmin[c];
                                bbox[(4*c+2)*COORD_W +: COORD_W] <= nxt_xmax[c];
                                bbox[(4*c+1)*COORD_W +: COORD_W] <= nxt_ymin[c];
                                bbox[(4*c)*COORD_W   +: COORD_W] <= nxt_ymax[c];
                                acc_xmin[c] <= '0;
                                acc_xmax[c] <= '0;
                                acc_ymin[c] <= '0;
                                acc_ymax[c] <= '0;
                            end
                            bbox_valid <= nxt_found;
                            frame_done <= 1'b1;
                            found      <= '0;
                        end else begin
                            for (int c = 0; c < NUM_CH; c++) begin
                                acc_xmin[c] <= nxt_xmin[c];
                                acc_xmax[c] <= nxt_xmax[c];
                                acc_ymin[c] <= nxt_ymin[c];
                                acc_ymax[c] <= nxt_ymax[c];
                            end
                            found <= nxt_found;
                        end
                    end
                    if (sink_eop)
                        state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_eee_imgproc_multi_bbox.sv
// tb/tb_eee_imgproc_multi_bbox.sv - randomized model-checked bench for eee_imgproc_multi_bbox
module tb_eee_imgproc_multi_bbox;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int NC = 4;
    localparam int CW = 11;
    localparam int BW = NC*4*CW;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [23:0]       sink_data = '0;
    logic              sink_valid = 1'b0;
    logic              sink_ready;
    logic              sink_sop = 1'b0;
    logic              sink_eop = 1'b0;
    logic [23:0]       source_data;
    logic              source_valid;
    logic              source_ready = 1'b1;
    logic              source_sop;
    logic              source_eop;
    logic [1:0]        mode = 2'd0;
    logic [NC*24-1:0]  thr_lo = '0;
    logic [NC*24-1:0]  thr_hi = '0;
    logic [BW-1:0]     bbox;
    logic [NC-1:0]     bbox_valid;
    logic              frame_done;

    eee_imgproc_multi_bbox #(.IMAGE_W(W), .IMAGE_H(H), .NUM_CH(NC), .COORD_W(CW),
                             .OVERLAY_RGB(24'hFF0000)) dut (
        .clk(clk), .reset_n(reset_n),
        .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
        .sink_sop(sink_sop), .sink_eop(sink_eop),
        .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
        .source_sop(source_sop), .source_eop(source_eop),
        .mode(mode), .thr_lo(thr_lo), .thr_hi(thr_hi),
        .bbox(bbox), .bbox_valid(bbox_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          fd_seen = 0;
    int          fd_exp = 0;
    int          rdy_mode = 0;
    int          gap_max = 0;
    bit          ignore_out = 1'b0;
    bit          chk_lat = 1'b0;
    logic [25:0] exp_out[$];        // {sop, eop, data} in output order
    int          acc_cyc[$];        // acceptance cycle of each forwarded beat
    logic [BW+NC-1:0] exp_box[$];   // {bbox_valid, bbox} per completed video frame
    logic [CW-1:0] m_box[NC][4];    // model of the published boxes: xmin,xmax,ymin,ymax
    bit          m_valid[NC];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit in_win(input logic [23:0] p, input int c);
        for (int k = 0; k < 3; k++) begin
            if (p[8*k +: 8] < thr_lo[24*c + 8*k +: 8] || p[8*k +: 8] > thr_hi[24*c + 8*k +: 8])
                return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit any_hit(input logic [23:0] p);
        for (int c = 0; c < NC; c++)
            if (in_win(p, c)) return 1'b1;
        return 1'b0;
    endfunction

    // Expected output for the i-th pixel of a frame sent with mode md.
    function automatic logic [23:0] model_pix(input logic [23:0] p, input int i, input logic [1:0] md);
        int px = i % W;
        int py = i / W;
        if (i >= W*H) return p;
        if (md == 2'd1 && any_hit(p)) return 24'hFFFFFF;
`ifdef EEE_BBOX_OVERLAY_EN
        if (md == 2'd2) begin
            for (int c = 0; c < NC; c++) begin
                if (m_valid[c]) begin
                    if ((px == m_box[c][0] || px == m_box[c][1]) && py >= m_box[c][2] && py <= m_box[c][3])
                        return 24'hFF0000;
                    if ((py == m_box[c][2] || py == m_box[c][3]) && px >= m_box[c][0] && px <= m_box[c][1])
                        return 24'hFF0000;
                end
            end
        end
`endif
        return p;
    endfunction

    // Box of a finished frame, computed from pixel positions directly.
    task automatic model_frame(input logic [23:0] px[$]);
        logic [BW-1:0] vec = '0;
        logic [NC-1:0] vld = '0;
        for (int c = 0; c < NC; c++) begin
            m_valid[c] = 1'b0;
            for (int j = 0; j < 4; j++) m_box[c][j] = '0;
        end
        for (int i = 0; i < px.size() && i < W*H; i++) begin
            for (int c = 0; c < NC; c++) begin
                if (in_win(px[i], c)) begin
                    if (!m_valid[c]) begin
                        m_box[c][0] = CW'(i % W); m_box[c][1] = CW'(i % W);
                        m_box[c][2] = CW'(i / W); m_box[c][3] = CW'(i / W);
                        m_valid[c] = 1'b1;
                    end else begin
                        if (i % W < m_box[c][0]) m_box[c][0] = CW'(i % W);
                        if (i % W > m_box[c][1]) m_box[c][1] = CW'(i % W);
                        if (i / W < m_box[c][2]) m_box[c][2] = CW'(i / W);
                        if (i / W > m_box[c][3]) m_box[c][3] = CW'(i / W);
                    end
                end
            end
        end
        for (int c = 0; c < NC; c++) begin
            vec[(4*c+3)*CW +: CW] = m_box[c][0];
            vec[(4*c+2)*CW +: CW] = m_box[c][1];
            vec[(4*c+1)*CW +: CW] = m_box[c][2];
            vec[(4*c)*CW   +: CW] = m_box[c][3];
            vld[c] = m_valid[c];
        end
        exp_box.push_back({vld, vec});
        fd_exp++;
    endtask

    task automatic send_beat(input logic [23:0] d, input bit sop, input bit eop, input bit fwd);
        int t = 0;
        bit acc = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk); #1;
        end
        sink_data = d; sink_sop = sop; sink_eop = eop; sink_valid = 1'b1;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = sink_ready;
            @(posedge clk);
            t++;
        end
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: got no sink_ready, expected acceptance within 200 cycles");
        end else if (fwd && !ignore_out) begin
            acc_cyc.push_back(cyc);
        end
        #1;
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    endtask

    task automatic send_video(input logic [23:0] px[$], input logic [1:0] md, input bit with_eop, input bit model_on);
        logic [23:0] hdr = {20'($urandom), 4'h0};
        bit last;
        mode = md;
        if (model_on) exp_out.push_back({2'b10, hdr});
        send_beat(hdr, 1'b1, 1'b0, model_on);
        mode = 2'($urandom);
        for (int i = 0; i < px.size(); i++) begin
            last = with_eop && (i == px.size() - 1);
            if (model_on) exp_out.push_back({1'b0, last, model_pix(px[i], i, md)});
            if (model_on && last) model_frame(px);
            send_beat(px[i], 1'b0, last, model_on);
        end
    endtask

    task automatic send_ctrl(input int n);
        logic [23:0] d;
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? {20'($urandom), 4'hF} : 24'($urandom);
            exp_out.push_back({(i == 0), (i == n - 1), d});
            send_beat(d, (i == 0), (i == n - 1), 1'b1);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_out.size() != 0 || exp_box.size() != 0) && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (t >= 500) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: got %0d beats and %0d boxes outstanding, expected 0", exp_out.size(), exp_box.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] rand_pix();
        logic [23:0] p = 24'($urandom);
        int c = $urandom_range(0, NC - 1);
        int lo, hi;
        if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k < 3; k++) begin
                lo = int'(thr_lo[24*c + 8*k +: 8]);
                hi = int'(thr_hi[24*c + 8*k +: 8]);
                if (lo <= hi) p[8*k +: 8] = 8'($urandom_range(lo, hi));
            end
        end
        return p;
    endfunction

    // Downstream ready: 0 always, 1 toggling, 2 random.
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 0)      source_ready = 1'b1;
        else if (rdy_mode == 1) source_ready = ~source_ready;
        else                    source_ready = 1'($urandom_range(0, 1));
    end

    // Output compare against the model queues.
    bit          prev_stall = 1'b0;
    logic [25:0] prev_beat = '0;
    initial forever begin
        logic [25:0] e;
        logic [BW+NC-1:0] b;
        int a;
        @(negedge clk);
        cyc++;
        if (reset_n && !ignore_out) begin
            if (source_valid) begin
                if (prev_stall)
                    check("hold", {source_sop, source_eop, source_data}, prev_beat);
                if (source_ready) begin
                    if (exp_out.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_beat: got %0h, expected no beat", source_data);
                    end else begin
                        e = exp_out.pop_front();
                        check("beat", {source_sop, source_eop, source_data}, e);
                    end
                    if (acc_cyc.size() != 0) begin
                        a = acc_cyc.pop_front();
                        if (chk_lat) check("latency", cyc, a + 1);
                    end
                end
            end
            prev_stall = source_valid && !source_ready;
            prev_beat  = {source_sop, source_eop, source_data};
            if (frame_done) begin
                fd_seen++;
                if (exp_box.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_frame_done: got pulse, expected none");
                end else begin
                    b = exp_box.pop_front();
                    check("bbox", {bbox_valid, bbox}, b);
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #500000;
        n_checks++; n_fail++;
        $display("FAIL watchdog: got no completion, expected end of test");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [23:0] px[$];
        logic [23:0] t2px[$];
        int          n, r, lo8, hi8, s;

        for (int c = 0; c < NC; c++) begin
            m_valid[c] = 1'b0;
            for (int j = 0; j < 4; j++) m_box[c][j] = '0;
        end
        thr_lo[23:0] = 24'hF00000; thr_hi[23:0] = 24'hFF1010;
        for (int c = 1; c < NC; c++) begin
            thr_lo[24*c +: 24] = 24'hFFFFFF; thr_hi[24*c +: 24] = 24'h000000;
        end
        for (int i = 0; i < W*H; i++) t2px.push_back(24'h202020);
        t2px[1] = 24'hF80808;
        t2px[7] = 24'hF80808;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_source_valid", source_valid, 1'b0);
        check("rst_sop_eop", {source_sop, source_eop}, 2'b00);
        check("rst_source_data", source_data, 24'h0);
        check("rst_bbox", bbox, '0);
        check("rst_bbox_valid", bbox_valid, 4'b0000);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_sink_ready", sink_ready, 1'b1);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // 1: mode 0 passthrough, 1-cycle latency, one frame_done
        chk_lat = 1'b1; gap_max = 0; rdy_mode = 0;
        px.delete();
        for (int i = 0; i < W*H; i++) px.push_back(24'(i * 24'h102030 + 5));
        send_video(px, 2'd0, 1'b1, 1'b1);
        drain();
        chk_lat = 1'b0;
        check("t1_frame_done_count", fd_seen, 1);

        // 2: red window on ch0
        send_video(t2px, 2'd0, 1'b1, 1'b1);
        drain();
        check("t2_bbox_ch0", bbox[4*CW-1:0], {11'd1, 11'd3, 11'd0, 11'd1});
        check("t2_bbox_valid", bbox_valid, 4'b0001);

`ifdef EEE_BBOX_OVERLAY_EN
        // 6: overlay of the previous frame's box
        check("t6_model_edge", model_pix(24'h123456, 2, 2'd2), 24'hFF0000);
        check("t6_model_inner", model_pix(24'h123456, 4, 2'd2), 24'h123456);
        send_video(t2px, 2'd2, 1'b1, 1'b1);
        drain();
`endif

        // 4: control packet then video
        s = fd_seen;
        send_ctrl(3);
        drain();
        check("t4_no_frame_done_on_ctrl", fd_seen, s);
        send_video(t2px, 2'd0, 1'b1, 1'b1);
        drain();
        check("t4_frame_done_after_video", fd_seen, s + 1);
        check("t4_bbox_ch0", bbox[4*CW-1:0], {11'd1, 11'd3, 11'd0, 11'd1});

        // 3: toggling ready, highlight mode
        rdy_mode = 1;
        px.delete();
        for (int i = 0; i < W*H; i++) px.push_back((i % 3 == 0) ? 24'hF80808 : 24'($urandom));
        send_video(px, 2'd1, 1'b1, 1'b1);
        drain();

        // 5: reset mid-frame, dropped beats, then full frame
        rdy_mode = 0;
        ignore_out = 1'b1;
        px.delete();
        for (int i = 0; i < 3; i++) px.push_back(24'hF80808);
        send_video(px, 2'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        exp_out.delete(); acc_cyc.delete(); exp_box.delete();
        for (int c = 0; c < NC; c++) begin
            m_valid[c] = 1'b0;
            for (int j = 0; j < 4; j++) m_box[c][j] = '0;
        end
        @(negedge clk);
        check("t5_rst_valid", source_valid, 1'b0);
        check("t5_rst_bbox", {bbox_valid, bbox}, '0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        ignore_out = 1'b0;
        send_beat(24'hABCDEF, 1'b0, 1'b0, 1'b0);
        send_beat(24'h123456, 1'b0, 1'b1, 1'b0);
        send_video(t2px, 2'd0, 1'b1, 1'b1);
        drain();
        check("t5_bbox_ch0", bbox[4*CW-1:0], {11'd1, 11'd3, 11'd0, 11'd1});
        check("t5_bbox_valid", bbox_valid, 4'b0001);

        // Randomized frames: thresholds, lengths, modes, restarts, control packets
        for (int f = 0; f < 30; f++) begin
            if (f % 5 == 0) begin
                drain();
                for (int c = 0; c < NC; c++) begin
                    for (int k = 0; k < 3; k++) begin
                        lo8 = $urandom_range(0, 255);
                        hi8 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(lo8, 255);
                        thr_lo[24*c + 8*k +: 8] = 8'(lo8);
                        thr_hi[24*c + 8*k +: 8] = 8'(hi8);
                    end
                end
            end
            rdy_mode = 2; gap_max = 2;
            r = $urandom_range(0, 9);
            if (r == 0) send_ctrl($urandom_range(1, 4));
            n = $urandom_range(1, W*H + 3);
            px.delete();
            for (int i = 0; i < n; i++) px.push_back(rand_pix());
            send_video(px, 2'($urandom), (r != 1), 1'b1);
        end
        drain();
        check("final_frame_done_count", fd_seen, fd_exp);
        check("final_queues_empty", exp_out.size() + exp_box.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
